// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the system-ID check master.
package sysid_check_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;
    localparam int   SYSID_DATA_W  = 32;

    function automatic logic is_read_state(input state_t s);
        return (s == RD_ID) || (s == RD_TS);
    endfunction

endpackage

// File: rtl/sysid_check_master_if.sv
// Avalon-MM read-only bus between the check master and the system-ID slave.
interface sysid_check_master_if;
    import sysid_check_pkg::*;

    logic                    avm_address;
    logic                    avm_read;
    logic [SYSID_DATA_W-1:0] avm_readdata;
    logic                    avm_waitrequest;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_readdata,
        output avm_waitrequest
    );

endinterface

// File: rtl/avm_wait_timer.sv
// Saturating count of consecutive waitrequest-high cycles; flags the stall that reaches the limit.
module avm_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Asserted during the stall cycle whose closing edge brings the count to the limit.
    assign expired_o = en_i && (count_q >= CNT_LAST);

endmodule

// File: rtl/sysid_check_master.sv
// Reads the system-ID slave (ID word, then timestamp) and reports whether both match the build values.
module sysid_check_master
    import sysid_check_pkg::*;
#(
    parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [SYSID_DATA_W-1:0] EXPECTED_TS    = 32'h622A_31A2,
    parameter int unsigned             TIMEOUT_CYCLES = 255,
    parameter bit                      START_ON_RESET = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    sysid_check_master_if.master    avm,
    output logic                    busy,
    output logic                    done,
    output logic                    id_ok,
    output logic                    ts_ok,
    output logic                    timeout,
    output logic [SYSID_DATA_W-1:0] id_value,
    output logic [SYSID_DATA_W-1:0] ts_value
);

    localparam state_t RESET_STATE = state_t'(START_ON_RESET ? RD_ID : IDLE);

    state_t                  state_q, state_d;
    logic [SYSID_DATA_W-1:0] id_value_q, id_value_d;
    logic [SYSID_DATA_W-1:0] ts_value_q, ts_value_d;
    logic                    id_ok_q, id_ok_d;
    logic                    ts_ok_q, ts_ok_d;
    logic                    timeout_q, timeout_d;
    logic                    timer_clr;
    logic                    timer_en;
    logic                    timer_expired;

    avm_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .clr_i     (timer_clr),
        .en_i      (timer_en),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d    = state_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
        timeout_d  = timeout_q;
        timer_clr  = 1'b1;
        timer_en   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RD_ID;
                    id_value_d = '0;
                    ts_value_d = '0;
                    id_ok_d    = 1'b0;
                    ts_ok_d    = 1'b0;
                    timeout_d  = 1'b0;
                end
            end
            RD_ID, RD_TS: begin
                timer_clr = 1'b0;
                timer_en  = avm.avm_waitrequest;
                if (!avm.avm_waitrequest) begin
                    // Completion re-arms the counter for the following read.
                    timer_clr = 1'b1;
                    if (state_q == RD_ID) begin
                        id_value_d = avm.avm_readdata;
                        state_d    = RD_TS;
                    end else begin
                        ts_value_d = avm.avm_readdata;
                        id_ok_d    = (id_value_q == EXPECTED_ID);
                        ts_ok_d    = (avm.avm_readdata == EXPECTED_TS);
                        state_d    = FIN;
                    end
                end else if (timer_expired) begin
                    timeout_d = 1'b1;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                    state_d   = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RESET_STATE;
            id_value_q <= '0;
            ts_value_q <= '0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
            timeout_q  <= timeout_d;
        end
    end

    // Reset state may already be RD_ID, so strobes are gated to stay low while reset is held.
    assign avm.avm_read    = reset_n & is_read_state(state_q);
    assign avm.avm_address = (state_q == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    assign busy            = reset_n & (state_q != IDLE);
    assign done            = (state_q == FIN);
    assign id_ok           = id_ok_q;
    assign ts_ok           = ts_ok_q;
    assign timeout         = timeout_q;
    assign id_value        = id_value_q;
    assign ts_value        = ts_value_q;

endmodule

// File: tb/tb_sysid_check_master.sv
// Directed bench for sysid_check_master against a modelled system-ID slave.
module tb_sysid_check_master;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'h622A_31A2;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic        wait_req = 1'b0;
    logic [31:0] id_word = 32'h0;
    logic [31:0] ts_word = 32'h0;
    logic        busy, done, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;
    int          errors = 0;
    int          checks = 0;

    sysid_check_master_if avm_bus ();

    assign avm_bus.avm_readdata    = avm_bus.avm_address ? ts_word : id_word;
    assign avm_bus.avm_waitrequest = wait_req;

    sysid_check_master #(
        .EXPECTED_ID    (EXP_ID),
        .EXPECTED_TS    (EXP_TS),
        .TIMEOUT_CYCLES (8),
        .START_ON_RESET (1'b1)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .avm      (avm_bus),
        .busy     (busy),
        .done     (done),
        .id_ok    (id_ok),
        .ts_ok    (ts_ok),
        .timeout  (timeout),
        .id_value (id_value),
        .ts_value (ts_value)
    );

    always #5 clock = ~clock;

    // Pulses start for one cycle and counts cycles until done (-1 if it never arrives).
    task automatic run_check(output int cyc);
        start = 1'b1;
        cyc   = 0;
        do begin
            @(negedge clock);
            start = 1'b0;
            cyc++;
        end while (!done && cyc < 60);
        if (!done) cyc = -1;
        $display("check: cycles=%0d id_ok=%b ts_ok=%b timeout=%b id=%h ts=%h",
                 cyc, id_ok, ts_ok, timeout, id_value, ts_value);
    endtask

    task automatic test_reset();
        id_word  = EXP_ID;
        ts_word  = EXP_TS;
        wait_req = 1'b0;
        start    = 1'b0;
        reset_n  = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if ({busy, done, id_ok, ts_ok, timeout, avm_bus.avm_read, avm_bus.avm_address} !== 7'b0 ||
            id_value !== 32'h0 || ts_value !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b ok=%b%b to=%b rd=%b id=%h ts=%h (want all 0)",
                     busy, done, id_ok, ts_ok, timeout, avm_bus.avm_read, id_value, ts_value);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (avm_bus.avm_read !== 1'b1 || avm_bus.avm_address !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL auto_cycle1: rd=%b addr=%b busy=%b (want 1 0 1)",
                     avm_bus.avm_read, avm_bus.avm_address, busy);
        end
        @(negedge clock);
        checks++;
        if (avm_bus.avm_read !== 1'b1 || avm_bus.avm_address !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL auto_cycle2: rd=%b addr=%b done=%b (want 1 1 0)",
                     avm_bus.avm_read, avm_bus.avm_address, done);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b1 || avm_bus.avm_read !== 1'b0 || {id_ok, ts_ok, timeout} !== 3'b110) begin
            errors++;
            $display("FAIL auto_cycle3: done=%b rd=%b ok/ok/to=%b (want 1 0 110)",
                     done, avm_bus.avm_read, {id_ok, ts_ok, timeout});
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || {id_ok, ts_ok, timeout} !== 3'b110 || ts_value !== EXP_TS) begin
            errors++;
            $display("FAIL auto_hold: done=%b busy=%b ok/ok/to=%b ts=%h (want 0 0 110 %h)",
                     done, busy, {id_ok, ts_ok, timeout}, ts_value, EXP_TS);
        end
    endtask

    task automatic test_ts_mismatch();
        ts_word = 32'h622A_31A3;
        start   = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if ({busy, avm_bus.avm_read, avm_bus.avm_address} !== 3'b110 ||
            {id_ok, ts_ok, timeout} !== 3'b000 || ts_value !== 32'h0) begin
            errors++;
            $display("FAIL ts_mm_cleared: busy/rd/addr=%b ok/ok/to=%b ts=%h (want 110 000 0)",
                     {busy, avm_bus.avm_read, avm_bus.avm_address}, {id_ok, ts_ok, timeout}, ts_value);
        end
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (done !== 1'b1 || {id_ok, ts_ok, timeout} !== 3'b100 ||
            ts_value !== 32'h622A_31A3 || id_value !== EXP_ID) begin
            errors++;
            $display("FAIL ts_mm_result: done=%b ok/ok/to=%b id=%h ts=%h (want 1 100 0 622a31a3)",
                     done, {id_ok, ts_ok, timeout}, id_value, ts_value);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || ts_value !== 32'h622A_31A3 || ts_ok !== 1'b0) begin
            errors++;
            $display("FAIL ts_mm_hold: done=%b ts=%h ts_ok=%b (want 0 622a31a3 0)", done, ts_value, ts_ok);
        end
        ts_word = EXP_TS;
    endtask

    task automatic test_id_mismatch();
        int cyc;
        id_word = 32'hDEAD_BEEF;
        run_check(cyc);
        checks++;
        if (cyc !== 3 || {id_ok, ts_ok, timeout} !== 3'b010 || id_value !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL id_mismatch: cyc=%0d ok/ok/to=%b id=%h (want 3 010 deadbeef)",
                     cyc, {id_ok, ts_ok, timeout}, id_value);
        end
        id_word = EXP_ID;
        @(negedge clock);
    endtask

    task automatic test_wait_states(input int stalls);
        int cyc;
        bit stable;
        stable   = 1'b1;
        cyc      = 0;
        wait_req = 1'b1;
        start    = 1'b1;
        do begin
            @(negedge clock);
            start = 1'b0;
            cyc++;
            if (cyc <= stalls + 1 &&
                (avm_bus.avm_read !== 1'b1 || avm_bus.avm_address !== 1'b0 || done !== 1'b0))
                stable = 1'b0;
            if (cyc == stalls + 1) wait_req = 1'b0;
        end while (!done && cyc < 60);
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL wait%0d_stable: rd/addr changed during stall (want rd=1 addr=0)", stalls);
        end
        checks++;
        if (cyc !== 3 + stalls) begin
            errors++;
            $display("FAIL wait%0d_latency: done at cycle %0d (want %0d)", stalls, cyc, 3 + stalls);
        end
        checks++;
        if ({id_ok, ts_ok, timeout} !== 3'b110) begin
            errors++;
            $display("FAIL wait%0d_result: ok/ok/to=%b (want 110)", stalls, {id_ok, ts_ok, timeout});
        end
        $display("wait-state check: stalls=%0d cycles=%0d", stalls, cyc);
        wait_req = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_timeout();
        int cyc;
        int read_cycles;
        int done_cnt;
        int done_at;
        cyc         = 0;
        read_cycles = 0;
        done_cnt    = 0;
        done_at     = 0;
        wait_req    = 1'b1;
        start       = 1'b1;
        repeat (16) begin
            @(negedge clock);
            start = 1'b0;
            cyc++;
            if (avm_bus.avm_read === 1'b1) read_cycles++;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = cyc;
            end
        end
        checks++;
        if (read_cycles !== 8) begin
            errors++;
            $display("FAIL timeout_read_len: read high %0d cycles (want 8)", read_cycles);
        end
        checks++;
        if (done_cnt !== 1 || done_at !== 9) begin
            errors++;
            $display("FAIL timeout_done: pulses=%0d at=%0d (want 1 at 9)", done_cnt, done_at);
        end
        checks++;
        if ({id_ok, ts_ok, timeout} !== 3'b001 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_result: ok/ok/to=%b busy=%b (want 001 0)", {id_ok, ts_ok, timeout}, busy);
        end
        $display("timeout check: read_cycles=%0d done_at=%0d", read_cycles, done_at);
        wait_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        int cyc;
        int done_cnt;
        int first_done;
        int last_done;
        cyc        = 0;
        done_cnt   = 0;
        first_done = 0;
        last_done  = 0;
        start      = 1'b1;
        repeat (20) begin
            @(negedge clock);
            cyc++;
            if (cyc == 10) start = 1'b0;
            if (done === 1'b1) begin
                done_cnt++;
                if (first_done == 0) first_done = cyc;
                last_done = cyc;
            end
        end
        checks++;
        if (done_cnt !== 3 || first_done !== 3 || last_done !== 11) begin
            errors++;
            $display("FAIL back_to_back: pulses=%0d first=%0d last=%0d (want 3 3 11)",
                     done_cnt, first_done, last_done);
        end
        checks++;
        if ({id_ok, ts_ok, timeout} !== 3'b110 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_result: ok/ok/to=%b busy=%b (want 110 0)", {id_ok, ts_ok, timeout}, busy);
        end
        $display("back-to-back: checks completed=%0d", done_cnt);
    endtask

    task automatic test_reset_mid_read();
        int cyc;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        checks++;
        if (avm_bus.avm_read !== 1'b1 || avm_bus.avm_address !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: rd=%b addr=%b (want 1 1)", avm_bus.avm_read, avm_bus.avm_address);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, id_ok, ts_ok, timeout, avm_bus.avm_read, avm_bus.avm_address} !== 7'b0 ||
            id_value !== 32'h0 || ts_value !== 32'h0) begin
            errors++;
            $display("FAIL midrst_outputs: busy=%b rd=%b addr=%b ok=%b%b id=%h ts=%h (want all 0)",
                     busy, avm_bus.avm_read, avm_bus.avm_address, id_ok, ts_ok, id_value, ts_value);
        end
        @(negedge clock);
        reset_n = 1'b1;
        cyc     = 1;
        while (!done && cyc < 60) begin
            @(negedge clock);
            cyc++;
        end
        checks++;
        if (cyc !== 3 || {id_ok, ts_ok, timeout} !== 3'b110 || ts_value !== EXP_TS) begin
            errors++;
            $display("FAIL midrst_recheck: cyc=%0d ok/ok/to=%b ts=%h (want 3 110 %h)",
                     cyc, {id_ok, ts_ok, timeout}, ts_value, EXP_TS);
        end
        $display("post-reset check: cycles=%0d", cyc);
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_ts_mismatch();
        test_id_mismatch();
        test_wait_states(4);
        test_wait_states(7);
        test_timeout();
        test_back_to_back();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
